// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared state encodings and sizing helper for the synchronous FIFO
package fifo_pkg;

    // Operation performed on the most recent clock edge.
    typedef enum logic [2:0] {
        ST_INIT   = 3'b000,
        ST_WRITE  = 3'b001,
        ST_WR_ERR = 3'b010,
        ST_NO_OP  = 3'b011,
        ST_READ   = 3'b100,
        ST_RD_ERR = 3'b101,
        ST_RD_WR  = 3'b110,
        ST_CLEAR  = 3'b111
    } fifo_state_e;

    // Occupancy must represent 0..DEPTH inclusive, so one bit wider than a pointer.
    function automatic int cnt_width(input int addr_width);
        return addr_width + 1;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// rtl/fifo_mem.sv - DATA_WIDTH x 2**ADDR_WIDTH storage, synchronous write port, registered read port
//
// Ports:
//   clk_i, reset_i        : clock, asynchronous active-high reset (read register only)
//   wr_en_i/wr_addr_i/wr_data_i : write port
//   rd_en_i/rd_addr_i     : read request; rd_data_o updates on the edge, holds otherwise
module fifo_mem #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  rd_en_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q;

    // The array itself carries no reset so it can map onto RAM.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - parameterised synchronous FIFO with registered flags, handshake pulses and op state
//
// Ports:
//   clk, reset            : rising-edge clock, asynchronous active-high reset
//   clear                 : synchronous flush, overrides wr_en/rd_en
//   wr_en, din            : write request and data
//   rd_en, dout           : read request and registered read data
//   full, empty, almost_full, almost_empty : level flags for the post-update count
//   wr_ack, wr_err, rd_ack, rd_err         : one-cycle outcome pulses
//   data_count            : occupancy 0..DEPTH
//   state                 : operation performed on the last edge
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 3,
    parameter int AF_LEVEL   = (2 ** ADDR_WIDTH) - 1,
    parameter int AE_LEVEL   = 1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               clear,
    input  logic                               wr_en,
    input  logic [DATA_WIDTH-1:0]              din,
    input  logic                               rd_en,
    output logic [DATA_WIDTH-1:0]              dout,
    output logic                               full,
    output logic                               empty,
    output logic                               almost_full,
    output logic                               almost_empty,
    output logic                               wr_ack,
    output logic                               wr_err,
    output logic                               rd_ack,
    output logic                               rd_err,
    output logic [cnt_width(ADDR_WIDTH)-1:0]   data_count,
    output logic [2:0]                         state
);

    localparam int CW = cnt_width(ADDR_WIDTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(2 ** ADDR_WIDTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

    logic [ADDR_WIDTH-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  full_q, full_d, empty_q, empty_d;
    logic                  af_q, af_d, ae_q, ae_d;
    logic                  wr_ack_q, wr_ack_d, wr_err_q, wr_err_d;
    logic                  rd_ack_q, rd_ack_d, rd_err_q, rd_err_d;
    fifo_state_e           state_q, state_d;
    logic                  wr_acc, rd_acc;

    // Acceptance uses the registered flags, so on a full FIFO a simultaneous
    // read frees a slot only for the next edge, and on an empty FIFO the
    // incoming word can never be read in the same edge (no bypass).
    assign wr_acc = wr_en & ~full_q  & ~clear;
    assign rd_acc = rd_en & ~empty_q & ~clear;

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk_i     (clk),
        .reset_i   (reset),
        .wr_en_i   (wr_acc),
        .wr_addr_i (tail_q),
        .wr_data_i (din),
        .rd_en_i   (rd_acc),
        .rd_addr_i (head_q),
        .rd_data_o (dout)
    );

    always_comb begin
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;
        wr_ack_d = 1'b0;
        wr_err_d = 1'b0;
        rd_ack_d = 1'b0;
        rd_err_d = 1'b0;
        state_d  = ST_NO_OP;

        if (clear) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            state_d = ST_CLEAR;
        end else begin
            if (wr_acc) tail_d = tail_q + ADDR_WIDTH'(1);
            if (rd_acc) head_d = head_q + ADDR_WIDTH'(1);
            case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            wr_ack_d = wr_acc;
            wr_err_d = wr_en & ~wr_acc;
            rd_ack_d = rd_acc;
            rd_err_d = rd_en & ~rd_acc;

            // An accepted operation outranks a rejected one on the same edge.
            if (wr_acc && rd_acc)  state_d = ST_RD_WR;
            else if (wr_acc)       state_d = ST_WRITE;
            else if (rd_acc)       state_d = ST_READ;
            else if (wr_en)        state_d = ST_WR_ERR;
            else if (rd_en)        state_d = ST_RD_ERR;
            else                   state_d = ST_NO_OP;
        end

        full_d  = (count_d == DEPTH_C);
        empty_d = (count_d == '0);
        af_d    = (count_d >= AF_C);
        ae_d    = (count_d <= AE_C);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            af_q     <= 1'b0;
            ae_q     <= 1'b1;
            wr_ack_q <= 1'b0;
            wr_err_q <= 1'b0;
            rd_ack_q <= 1'b0;
            rd_err_q <= 1'b0;
            state_q  <= ST_INIT;
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            af_q     <= af_d;
            ae_q     <= ae_d;
            wr_ack_q <= wr_ack_d;
            wr_err_q <= wr_err_d;
            rd_ack_q <= rd_ack_d;
            rd_err_q <= rd_err_d;
            state_q  <= state_d;
        end
    end

    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign wr_ack       = wr_ack_q;
    assign wr_err       = wr_err_q;
    assign rd_ack       = rd_ack_q;
    assign rd_err       = rd_err_q;
    assign data_count   = count_q;
    assign state        = state_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb/tb_sync_fifo_param.sv - randomized and directed self-checking bench for sync_fifo_param
module tb_sync_fifo_param;

    localparam int DW    = 32;
    localparam int AW    = 3;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          clear = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
    logic [DW-1:0] din = '0;
    logic [DW-1:0] dout;
    logic          full, empty, almost_full, almost_empty;
    logic          wr_ack, wr_err, rd_ack, rd_err;
    logic [AW:0]   data_count;
    logic [2:0]    state;

    sync_fifo_param dut (
        .clk(clk), .reset(rst), .clear(clear), .wr_en(wr_en), .din(din), .rd_en(rd_en),
        .dout(dout), .full(full), .empty(empty), .almost_full(almost_full),
        .almost_empty(almost_empty), .wr_ack(wr_ack), .wr_err(wr_err), .rd_ack(rd_ack),
        .rd_err(rd_err), .data_count(data_count), .state(state)
    );

    logic       w_clear = 1'b0, w_wr = 1'b0, w_rd = 1'b0;
    logic [7:0] w_din = '0, w_dout;
    logic       w_full, w_empty, w_af, w_ae, w_wack, w_werr, w_rack, w_rerr;
    logic [4:0] w_count;
    logic [2:0] w_state;

    sync_fifo_param #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut_w (
        .clk(clk), .reset(rst), .clear(w_clear), .wr_en(w_wr), .din(w_din), .rd_en(w_rd),
        .dout(w_dout), .full(w_full), .empty(w_empty), .almost_full(w_af),
        .almost_empty(w_ae), .wr_ack(w_wack), .wr_err(w_werr), .rd_ack(w_rack),
        .rd_err(w_rerr), .data_count(w_count), .state(w_state)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: a queue holding FIFO contents plus last-edge outcomes.
    logic [DW-1:0] mq[$];
    logic [DW-1:0] m_dout = '0;
    logic          m_wack = 1'b0, m_werr = 1'b0, m_rack = 1'b0, m_rerr = 1'b0;
    int            m_state = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_dout = '0;
        m_wack = 1'b0; m_werr = 1'b0; m_rack = 1'b0; m_rerr = 1'b0;
        m_state = 0;
    endtask

    task automatic model_update();
        bit wa, ra;
        m_wack = 1'b0; m_werr = 1'b0; m_rack = 1'b0; m_rerr = 1'b0;
        if (clear) begin
            mq.delete();
            m_state = 7;
        end else begin
            wa = wr_en && (mq.size() < DEPTH);
            ra = rd_en && (mq.size() > 0);
            if (ra) m_dout = mq.pop_front();
            if (wa) mq.push_back(din);
            m_wack = wa; m_werr = wr_en && !wa;
            m_rack = ra; m_rerr = rd_en && !ra;
            if (wa && ra)  m_state = 6;
            else if (wa)   m_state = 1;
            else if (ra)   m_state = 4;
            else if (wr_en) m_state = 2;
            else if (rd_en) m_state = 5;
            else           m_state = 3;
        end
    endtask

    task automatic compare_model();
        int n;
        n = mq.size();
        chk("dout",         dout,         m_dout);
        chk("data_count",   data_count,   n);
        chk("full",         full,         n == DEPTH);
        chk("empty",        empty,        n == 0);
        chk("almost_full",  almost_full,  n >= DEPTH - 1);
        chk("almost_empty", almost_empty, n <= 1);
        chk("wr_ack",       wr_ack,       m_wack);
        chk("wr_err",       wr_err,       m_werr);
        chk("rd_ack",       rd_ack,       m_rack);
        chk("rd_err",       rd_err,       m_rerr);
        chk("state",        state,        m_state);
    endtask

    task automatic step(input logic c, input logic w, input logic [DW-1:0] d, input logic r);
        clear = c; wr_en = w; din = d; rd_en = r;
        @(posedge clk);
        model_update();
        @(negedge clk);
        compare_model();
    endtask

    task automatic step_w(input logic w, input logic [7:0] d, input logic r);
        w_wr = w; w_din = d; w_rd = r;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_dout"},  dout,         0);
        chk({tag, "_count"}, data_count,   0);
        chk({tag, "_empty"}, empty,        1);
        chk({tag, "_ae"},    almost_empty, 1);
        chk({tag, "_full"},  full,         0);
        chk({tag, "_af"},    almost_full,  0);
        chk({tag, "_acks"},  {wr_ack, wr_err, rd_ack, rd_err}, 0);
        chk({tag, "_state"}, state,        0);
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        chk_reset_vals("rst");
        rst = 1'b0;

        // Fill to full, then overflow
        for (int i = 0; i < 8; i++) begin
            step(0, 1, DW'(i + 1), 0);
            chk("fill_wr_ack", wr_ack, 1);
        end
        chk("fill_full", full, 1);
        chk("fill_af", almost_full, 1);
        chk("fill_count", data_count, 8);
        step(0, 1, 32'h9, 0);
        chk("ovf_wr_err", wr_err, 1);
        chk("ovf_state", state, 3'b010);

        // Drain in order, then underflow
        for (int i = 0; i < 8; i++) begin
            step(0, 0, '0, 1);
            chk("drain_dout", dout, i + 1);
            chk("drain_rd_ack", rd_ack, 1);
        end
        chk("drain_empty", empty, 1);
        step(0, 0, '0, 1);
        chk("udf_rd_err", rd_err, 1);
        chk("udf_dout", dout, 8);

        // Steady count 4 with simultaneous wr/rd, pointers wrap
        for (int i = 0; i < 4; i++) step(0, 1, $urandom(), 0);
        for (int i = 0; i < 10; i++) begin
            step(0, 1, $urandom(), 1);
            chk("rdwr_count", data_count, 4);
            chk("rdwr_state", state, 3'b110);
        end
        for (int i = 0; i < 4; i++) step(0, 0, '0, 1);

        // Full with wr+rd, then empty with wr+rd
        for (int i = 0; i < 8; i++) step(0, 1, $urandom(), 0);
        step(0, 1, $urandom(), 1);
        chk("fullrw_rd_ack", rd_ack, 1);
        chk("fullrw_wr_err", wr_err, 1);
        chk("fullrw_count", data_count, 7);
        for (int i = 0; i < 7; i++) step(0, 0, '0, 1);
        step(0, 1, 32'h77, 1);
        chk("emptyrw_wr_ack", wr_ack, 1);
        chk("emptyrw_rd_err", rd_err, 1);
        chk("emptyrw_count", data_count, 1);

        // Clear beats a write
        for (int i = 0; i < 4; i++) step(0, 1, $urandom(), 0);
        chk("preclr_count", data_count, 5);
        step(1, 1, $urandom(), 0);
        chk("clr_count", data_count, 0);
        chk("clr_empty", empty, 1);
        chk("clr_state", state, 3'b111);
        chk("clr_wr_ack", wr_ack, 0);

        // Random traffic with alternating write/read bias
        for (int seg = 0; seg < 8; seg++) begin
            for (int i = 0; i < 50; i++) begin
                logic c, w, r;
                c = ($urandom_range(0, 40) == 0);
                w = (seg % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
                r = (seg % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
                step(c, w, $urandom(), r);
            end
        end

        // Reset between edges while a write is pending
        step(0, 1, 32'hA5A5_5A5A, 0);
        step(0, 1, 32'h1234_5678, 1);
        wr_en = 1'b1; din = 32'hDEAD_BEEF; rd_en = 1'b0; clear = 1'b0;
        #2 rst = 1'b1;
        model_reset();
        #1 chk_reset_vals("midrst");
        @(negedge clk);
        wr_en = 1'b0;
        compare_model();
        rst = 1'b0;
        step(0, 1, 32'hCAFE_F00D, 0);
        chk("postrst_wr_ack", wr_ack, 1);
        chk("postrst_count", data_count, 1);
        step(0, 0, '0, 1);
        chk("postrst_dout", dout, 32'hCAFE_F00D);

        // 8-bit x 16-entry instance
        for (int i = 0; i < 16; i++) begin
            step_w(1, 8'(i + 1), 0);
            if (i == 14) chk("w_full_at15", w_full, 0);
        end
        chk("w_full_at16", w_full, 1);
        chk("w_count16", w_count, 16);
        step_w(1, 8'hFF, 0);
        chk("w_ovf_err", w_werr, 1);
        step_w(0, 8'h00, 1);
        chk("w_rd1", w_dout, 8'h01);
        step_w(0, 8'h00, 1);
        chk("w_rd2", w_dout, 8'h02);
        chk("w_count14", w_count, 14);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sync_fifo_param.md
SYNC_FIFO_PARAM -- requirements
Module: sync_fifo_param

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, bits per entry.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 3, pointer width; DEPTH = 2**ADDR_WIDTH entries.
REQ-003 The block SHALL have parameter AF_LEVEL, default DEPTH-1, almost_full threshold (count >= AF_LEVEL).
REQ-004 The block SHALL have parameter AE_LEVEL, default 1, almost_empty threshold (count <= AE_LEVEL).
REQ-005 The block SHALL have one clock, and its reset SHALL be asynchronous and active-high.
REQ-006 The block SHALL have port clk, input, 1 bit, rising-edge clock.
REQ-007 The block SHALL have port reset, input, 1 bit, asynchronous active-high reset.
REQ-008 The block SHALL have port clear, input, 1 bit, synchronous flush.
REQ-009 The block SHALL have port wr_en, input, 1 bit, write request.
REQ-010 The block SHALL have port din, input, DATA_WIDTH bits, write data.
REQ-011 The block SHALL have port rd_en, input, 1 bit, read request.
REQ-012 The block SHALL have port dout, output, DATA_WIDTH bits, registered read data.
REQ-013 The block SHALL have ports full, empty, almost_full and almost_empty, outputs, 1 bit each, level flags.
REQ-014 The block SHALL have ports wr_ack, wr_err, rd_ack and rd_err, outputs, 1 bit each, one-cycle pulses.
REQ-015 The block SHALL have port data_count, output, ADDR_WIDTH+1 bits, occupancy 0..DEPTH.
REQ-016 The block SHALL have port state, output, 3 bits, registered operation state.

Function
REQ-017 Inputs SHALL be sampled on the rising edge of clk, and every output SHALL be registered.
REQ-018 A write SHALL be accepted when wr_en=1 and not full (or when rd_en=1 is accepted in the same cycle while full is 0): mem[tail]<=din, tail<=tail+1 modulo DEPTH.
REQ-019 A read SHALL be accepted when rd_en=1 and not empty: dout<=mem[head], head<=head+1 modulo DEPTH; dout SHALL be valid in the cycle rd_ack=1.
REQ-020 dout SHALL hold its previous value in any cycle without an accepted read.
REQ-021 wr_en while full with no accepted read SHALL give wr_err=1 for one cycle with no change to pointers or memory.
REQ-022 rd_en while empty SHALL give rd_err=1 for one cycle with dout and pointers unchanged.
REQ-023 Simultaneous wr_en and rd_en with 0<count<DEPTH: both SHALL be accepted, count unchanged, wr_ack=rd_ack=1.
REQ-024 Simultaneous wr_en and rd_en when full: the read SHALL be accepted and the write rejected (rd_ack=1, wr_err=1, count-1).
REQ-025 Simultaneous wr_en and rd_en when empty: the write SHALL be accepted and the read rejected (wr_ack=1, rd_err=1, count+1); the written data SHALL NOT bypass to dout.
REQ-026 data_count SHALL change by +1 on a write alone, -1 on a read alone, and 0 on both or neither.
REQ-027 full SHALL equal (count==DEPTH), empty SHALL equal (count==0), and almost flags SHALL follow REQ-003/REQ-004; all flags SHALL reflect the post-update count.
REQ-028 Pointers SHALL wrap from DEPTH-1 to 0 with no flag glitch.
REQ-029 State encoding SHALL be INIT=000, WRITE=001, WR_ERR=010, NO_OP=011, READ=100, RD_ERR=101, RD_WR=110, CLEAR=111; state SHALL give the operation performed on the last edge.
REQ-030 On an edge with both an error and an accept, state SHALL be the accepted operation (WRITE or READ).
REQ-031 State SHALL be NO_OP when neither request is active.
REQ-032 clear=1 SHALL take priority over wr_en and rd_en: head=tail=count=0, empty=1, acks/errs 0, state=CLEAR, dout held, memory untouched.

Reset
REQ-033 Reset assertion SHALL immediately set head=tail=0, data_count=0, dout=0, empty=1, almost_empty=1, full=0, almost_full=0, all acks/errs 0 and state=INIT, regardless of clk.
REQ-034 Memory contents SHALL NOT be reset.
REQ-035 Reset asserted mid-operation SHALL discard any in-flight request.
REQ-036 The first edge after reset deassertion SHALL process requests normally.

Structure
REQ-037 The state encodings and the count-width helper SHALL be defined in shared package fifo_pkg.
REQ-038 Storage SHALL be a sub-module fifo_mem (DATA_WIDTH x DEPTH, one synchronous write port, one registered read port).
REQ-039 Pointer, count and flag logic SHALL reside in sync_fifo_param.

Verification
REQ-040 Defaults: reset, 8 writes 0x1..0x8 -> wr_ack x8, full=1 and almost_full=1 after the 8th, data_count=8, 9th write -> wr_err=1, state=WR_ERR.
REQ-041 The bench SHALL then perform 8 reads -> dout 0x1..0x8 in order with rd_ack, empty=1 after the last, 9th read -> rd_err=1, dout stays 0x8.
REQ-042 count=4 plus wr_en&rd_en for 10 cycles -> count stays 4, state=RD_WR, pointers wrap past 7 with data order preserved.
REQ-043 Full, wr+rd -> rd_ack=1, wr_err=1, count=7; empty, wr+rd -> wr_ack=1, rd_err=1, count=1.
REQ-044 count=5, clear with wr_en=1 -> count=0, empty=1, state=CLEAR, no wr_ack.
REQ-045 Reset asserted between edges during a write -> outputs at reset values immediately.
REQ-046 DATA_WIDTH=8, ADDR_WIDTH=4 -> full at 16 entries.
